// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge
// Load/store bridge between the MEM pipeline stage and the data-memory model.
// Takes one load or store at a time, rejects misaligned accesses without
// touching memory, runs the memory command/data handshake and returns a
// single-cycle response. Load data is lane-aligned and sign/zero-extended.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        pipeline request handshake (ready only in IDLE)
//   req_wen, req_addr,         store flag, byte address,
//   req_size, req_unsigned,    size code (1/2/4/8 bytes), zero-extend loads,
//   req_wdata                  store data (low bytes)
//   resp_valid/resp_rdata/     one-cycle completion pulse, extended load data,
//   resp_err                   misaligned or timed-out flag
//   addr_valid/addr_ready      memory command handshake
//   data_valid/data_ready      read data handshake; data_ready doubles as the
//                              write-data valid for stores
//   Mwout, Maddr, Men, Mlen,   memory command fields
//   MdataIn, MdataOut          read doubleword (aligned), store data
module lsu_mem_bridge #(
  parameter int TIMEOUT = 64,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            addr_valid,
  input  logic            addr_ready,
  input  logic            data_valid,
  output logic            data_ready,
  output logic            Mwout,
  output logic [XLEN-1:0] Maddr,
  output logic            Men,
  output logic [31:0]     Mlen,
  input  logic [XLEN-1:0] MdataIn,
  output logic [XLEN-1:0] MdataOut
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } state_t;

  state_t            state_reg, state_next;
  logic              wen_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [XLEN-1:0]   rdata_reg;

  logic              misaligned;
  logic              timed_out;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ext [4];
  logic [XLEN-1:0]   load_data;

  // Natural alignment: the low size bits of the address must be zero.
  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign timed_out = (cnt_reg == CNT_LAST);

  // MdataIn is the whole aligned doubleword; bring the addressed byte lane
  // down to bit 0 before truncating to the access size.
  assign shifted = MdataIn >> {addr_reg[2:0], 3'b000};

  // One extended candidate per access size; the latched size picks one.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_ext
    localparam int W = 8 << gi;
    if (W < XLEN) begin : g_part
      assign ext[gi] = {{(XLEN - W){~uns_reg & shifted[W-1]}}, shifted[W-1:0]};
    end else begin : g_full
      assign ext[gi] = shifted;
    end
  end

  assign load_data = ext[size_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= 2'd0;
      uns_reg   <= 1'b0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            wen_reg   <= req_wen;
            addr_reg  <= req_addr;
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            wdata_reg <= req_wdata;
            err_reg   <= misaligned;
            rdata_reg <= '0;
          end
        end
        CMD: begin
          // Clearing here means every WAIT starts counting from zero.
          cnt_reg <= '0;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // Data arriving on the expiry cycle still wins.
          if (data_valid) begin
            rdata_reg <= load_data;
            err_reg   <= 1'b0;
          end else if (timed_out) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) state_next = misaligned ? RESP : CMD;
      end
      CMD: begin
        if (addr_ready) state_next = wen_reg ? RESP : WAIT;
      end
      WAIT: begin
        if (data_valid || timed_out) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    addr_valid = 1'b0;
    data_ready = 1'b0;
    Mwout      = 1'b0;
    Maddr      = '0;
    Men        = 1'b0;
    Mlen       = 32'd0;
    MdataOut   = '0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      CMD: begin
        addr_valid = 1'b1;
        Men        = 1'b1;
        Mwout      = wen_reg;
        Maddr      = addr_reg;
        Mlen       = 32'd1 << size_reg;
        MdataOut   = wdata_reg;
        // Store write data travels with the command.
        data_ready = wen_reg;
      end
      WAIT: begin
        Men        = 1'b1;
        Maddr      = addr_reg;
        Mlen       = 32'd1 << size_reg;
        data_ready = 1'b1;
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_err   = err_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge (TIMEOUT = 8). A reactive memory
// responder answers the command/data handshake with configurable delays and
// a reference model predicts response timing, error and extended load data.
module tb_lsu_mem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        Mwout;
  logic [63:0] Maddr;
  logic        Men;
  logic [31:0] Mlen;
  logic [63:0] MdataIn = '0;
  logic [63:0] MdataOut;

  int pass_cnt = 0;
  int total_cnt = 0;

  lsu_mem_bridge #(.TIMEOUT(TMO), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .data_valid(data_valid), .data_ready(data_ready),
    .Mwout(Mwout), .Maddr(Maddr), .Men(Men), .Mlen(Mlen),
    .MdataIn(MdataIn), .MdataOut(MdataOut)
  );

  initial forever #5 clk = ~clk;

  // Reference: pick (1<<size) bytes starting at addr%8, little-endian,
  // then extend from the top byte unless unsigned.
  function automatic logic [63:0] ref_load(input logic [63:0] mdata,
                                           input logic [63:0] addr,
                                           input logic [1:0] size,
                                           input logic uns);
    int n = 1 << size;
    int base = int'(addr % 8);
    logic [63:0] v = '0;
    logic [63:0] tmp;
    for (int i = 0; i < n; i++) begin
      tmp = mdata >> (8 * (base + i));
      v[8*i +: 8] = tmp[7:0];
    end
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  function automatic bit ref_misaligned(input logic [63:0] addr, input logic [1:0] size);
    return (addr % (64'd1 << size)) != 0;
  endfunction

  // One transaction: request at cycle 0, then respond reactively. ar_delay is
  // the number of cycles addr_valid is held before addr_ready; dv_delay is the
  // WAIT cycle (0-based) in which data_valid is given, >= TMO means never.
  task automatic run_op(input string name, input logic wen, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input logic [63:0] mdata, input int ar_delay, input int dv_delay);
    bit          mis = ref_misaligned(addr, size);
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          got_cyc = -1;
    int          av_n = 0;
    int          av_first = -1;
    int          wait_n = 0;
    bit          touched = 0;
    logic [63:0] got_rdata = '0;
    logic        got_err = 1'b0;

    if (mis) begin
      exp_err = 1'b1; exp_rdata = '0; exp_cyc = 1;
    end else if (wen) begin
      exp_err = 1'b0; exp_rdata = '0; exp_cyc = 2 + ar_delay;
    end else if (dv_delay < TMO) begin
      exp_err = 1'b0; exp_rdata = ref_load(mdata, addr, size, uns);
      exp_cyc = 3 + ar_delay + dv_delay;
    end else begin
      exp_err = 1'b1; exp_rdata = '0; exp_cyc = 2 + ar_delay + TMO;
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; MdataIn = mdata;
    addr_ready = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    else pass_cnt++;

    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; addr_ready = 1'b0; data_valid = 1'b0;
      @(negedge clk);
      if (addr_valid || Men || Mwout || data_ready) touched = 1;
      if (resp_valid) begin
        got_cyc = c; got_rdata = resp_rdata; got_err = resp_err;
        break;
      end
      if (addr_valid) begin
        av_n++;
        if (av_n == 1) begin
          av_first = c;
          total_cnt++;
          if (Maddr !== addr) $display("FAIL %s Maddr: got %h want %h", name, Maddr, addr);
          else pass_cnt++;
          total_cnt++;
          if ({Men, Mwout, data_ready, Mlen} !== {1'b1, wen, wen, 32'd1 << size})
            $display("FAIL %s cmd {Men,Mwout,data_ready,Mlen}: got %b %b %b %0d want 1 %b %b %0d",
                     name, Men, Mwout, data_ready, Mlen, wen, wen, 32'd1 << size);
          else pass_cnt++;
          if (wen) begin
            total_cnt++;
            if (MdataOut !== wdata) $display("FAIL %s MdataOut: got %h want %h", name, MdataOut, wdata);
            else pass_cnt++;
          end
        end
        if (av_n - 1 >= ar_delay) addr_ready = 1'b1;
      end else if (data_ready) begin
        if (wait_n == dv_delay) data_valid = 1'b1;
        wait_n++;
      end
    end

    $display("op %s wen=%0b addr=%h size=%0d uns=%0b -> cyc=%0d err=%0b rdata=%h",
             name, wen, addr, size, uns, got_cyc, got_err, got_rdata);

    total_cnt++;
    if (got_cyc != exp_cyc) $display("FAIL %s resp cycle: got %0d want %0d", name, got_cyc, exp_cyc);
    else pass_cnt++;
    total_cnt++;
    if (got_err !== exp_err) $display("FAIL %s resp_err: got %b want %b", name, got_err, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (got_rdata !== exp_rdata) $display("FAIL %s resp_rdata: got %h want %h", name, got_rdata, exp_rdata);
    else pass_cnt++;
    if (mis) begin
      total_cnt++;
      if (touched) $display("FAIL %s memory touched on misaligned: got 1 want 0", name);
      else pass_cnt++;
    end else begin
      total_cnt++;
      if (av_first != 1) $display("FAIL %s first addr_valid cycle: got %0d want 1", name, av_first);
      else pass_cnt++;
    end
    if (!mis && !wen && dv_delay >= TMO) begin
      total_cnt++;
      if (wait_n != TMO) $display("FAIL %s WAIT cycles before timeout: got %0d want %0d", name, wait_n, TMO);
      else pass_cnt++;
    end

    // Response must be a single-cycle pulse, followed by IDLE.
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL %s after resp {resp_valid,req_ready}: got %b%b want 01", name, resp_valid, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, addr_valid, data_ready, Men, Mwout} !== 7'b1000000)
      $display("FAIL reset control: got %b want 1000000",
               {req_ready, resp_valid, resp_err, addr_valid, data_ready, Men, Mwout});
    else pass_cnt++;
    total_cnt++;
    if ({resp_rdata, Maddr, Mlen, MdataOut} !== '0)
      $display("FAIL reset data: got rdata=%h Maddr=%h Mlen=%0d MdataOut=%h want all 0",
               resp_rdata, Maddr, Mlen, MdataOut);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    run_op("store_d", 1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h0, 0, 0);
    run_op("store_b_slow", 1'b1, 64'h8000_0007, 2'd0, 1'b0, 64'h0000_0000_0000_00A5, 64'h0, 2, 0);
  endtask

  task automatic test_load_ext();
    run_op("lb", 1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 0, 2);
    run_op("lbu", 1'b0, 64'h8000_0003, 2'd0, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 0, 2);
    run_op("lw", 1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 0);
    run_op("lwu", 1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 1);
    run_op("lh_hi", 1'b0, 64'h8000_0006, 2'd1, 1'b0, 64'h0, 64'h8123_0000_0000_0000, 0, 3);
  endtask

  task automatic test_misaligned();
    run_op("lh_mis", 1'b0, 64'h8000_0001, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("sd_mis", 1'b1, 64'h8000_0004, 2'd3, 1'b0, 64'h1234, 64'h0, 0, 0);
  endtask

  task automatic test_timeout();
    run_op("ld_tmo", 1'b0, 64'h8000_0020, 2'd3, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 0, TMO + 5);
    // A stray data_valid while idle must not produce a response.
    @(posedge clk); #1;
    data_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    data_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL stale_dv {resp_valid,req_ready}: got %b%b want 01", resp_valid, req_ready);
    else pass_cnt++;
    // Data on the last possible WAIT cycle still wins over the timeout.
    run_op("ld_edge", 1'b0, 64'h8000_0028, 2'd3, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 0, TMO - 1);
  endtask

  task automatic test_reset_mid_op();
    bit in_wait = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008; req_size = 2'd3;
    req_unsigned = 1'b0; MdataIn = 64'hCAFE_F00D_1234_5678;
    for (int c = 0; c < 6 && !in_wait; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; addr_ready = 1'b0;
      @(negedge clk);
      if (addr_valid) addr_ready = 1'b1;
      else if (data_ready) in_wait = 1;
    end
    total_cnt++;
    if (!in_wait) $display("FAIL rst_mid reached WAIT: got 0 want 1");
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, addr_valid, data_ready, Men, Mwout} !== 7'b1000000)
      $display("FAIL rst_mid control: got %b want 1000000",
               {req_ready, resp_valid, resp_err, addr_valid, data_ready, Men, Mwout});
    else pass_cnt++;
    total_cnt++;
    if ({resp_rdata, Maddr, Mlen, MdataOut} !== '0)
      $display("FAIL rst_mid data: got rdata=%h Maddr=%h Mlen=%0d MdataOut=%h want all 0",
               resp_rdata, Maddr, Mlen, MdataOut);
    else pass_cnt++;
    @(posedge clk); #1;
    data_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL rst_mid stale dv {resp_valid,req_ready}: got %b%b want 01", resp_valid, req_ready);
    else pass_cnt++;
    run_op("after_rst", 1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic [63:0] addr = {32'h8000_0000, $urandom};
      logic        wen = 1'($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      run_op($sformatf("rnd%0d", k), wen, addr, size, 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 2), $urandom_range(0, TMO + 1));
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_misaligned();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
